// File: rtl/pattern_scan_pkg.sv
// Shared types and default parameters for the serial pattern scanner.
package pattern_scan_pkg;

  localparam int unsigned DEF_WORD_W  = 32;
  localparam int unsigned DEF_PAT_LEN = 3;
  localparam logic [2:0]  DEF_PATTERN = 3'b110;
  localparam int unsigned DEF_CNT_W   = 6;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } scan_state_e;

endpackage

// File: rtl/pat_window_det.sv
// Sliding PAT_LEN-bit window with a seen-bit counter; flags a match on the shift
// that completes PATTERN once enough bits of the current word have arrived.
module pat_window_det
  import pattern_scan_pkg::*;
#(
  parameter int unsigned          PAT_LEN = DEF_PAT_LEN,
  parameter logic [PAT_LEN-1:0]   PATTERN = PAT_LEN'(DEF_PATTERN)
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic shift_en,
  input  logic bit_in,
  output logic hit
);

  localparam int unsigned SEEN_W = $clog2(PAT_LEN + 1);

  logic [PAT_LEN-1:0] win_q;
  logic [PAT_LEN-1:0] win_d;
  logic [SEEN_W-1:0]  seen_q;
  logic               full;

  // Truncating cast keeps this valid for PAT_LEN == 1.
  always_comb begin
    win_d = PAT_LEN'({win_q, bit_in});
    full  = (seen_q >= SEEN_W'(PAT_LEN - 1));
    hit   = shift_en && full && (win_d == PATTERN);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      win_q  <= '0;
      seen_q <= '0;
    end else if (clr) begin
      win_q  <= '0;
      seen_q <= '0;
    end else if (shift_en) begin
      win_q <= win_d;
      if (seen_q != SEEN_W'(PAT_LEN))
        seen_q <= seen_q + SEEN_W'(1);
    end
  end

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Accepts a parallel word, serialises it MSB first through the pattern window
// and reports per-bit hits plus a saturating per-word match count.
module pattern_scan_ctrl
  import pattern_scan_pkg::*;
#(
  parameter int unsigned        WORD_W  = DEF_WORD_W,
  parameter int unsigned        PAT_LEN = DEF_PAT_LEN,
  parameter logic [PAT_LEN-1:0] PATTERN = PAT_LEN'(DEF_PATTERN),
  parameter int unsigned        CNT_W   = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ser_bit,
  output logic              det_hit,
  output logic [CNT_W-1:0]  match_cnt,
  output logic              busy,
  output logic              done
);

  localparam int unsigned IDX_W = $clog2(WORD_W + 1);

  scan_state_e       state_q;
  scan_state_e       state_d;
  logic              live_q;
  logic [WORD_W-1:0] word_q;
  logic [IDX_W-1:0]  idx_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              hit_q;
  logic              xfer;
  logic              shift_en;
  logic              hit;

  always_comb begin
    state_d    = state_q;
    word_ready = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    ser_bit    = 1'b0;
    xfer       = 1'b0;
    shift_en   = 1'b0;
    case (state_q)
      IDLE: begin
        // live_q holds ready low until the first edge after reset release.
        word_ready = live_q;
        xfer       = word_valid && live_q;
        if (xfer)
          state_d = SHIFT;
      end
      SHIFT: begin
        busy     = 1'b1;
        shift_en = 1'b1;
        ser_bit  = word_q[WORD_W-1];
        if (idx_q == IDX_W'(WORD_W - 1))
          state_d = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      word_q <= '0;
      idx_q  <= '0;
      cnt_q  <= '0;
      hit_q  <= 1'b0;
    end else begin
      hit_q <= hit;
      if (xfer) begin
        word_q <= word_in;
        idx_q  <= '0;
        cnt_q  <= '0;
      end else if (shift_en) begin
        word_q <= word_q << 1;
        idx_q  <= idx_q + IDX_W'(1);
        if (hit && (cnt_q != '1))
          cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  pat_window_det #(
    .PAT_LEN (PAT_LEN),
    .PATTERN (PATTERN)
  ) u_det (
    .clk      (clk),
    .rstn     (rstn),
    .clr      (xfer),
    .shift_en (shift_en),
    .bit_in   (word_q[WORD_W-1]),
    .hit      (hit)
  );

  assign det_hit   = hit_q;
  assign match_cnt = cnt_q;

endmodule
